dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDRW, default 10, meaning data-memory word-address width.
REQ-002 The block SHALL have parameter DATAW, default 32, meaning data width.
REQ-003 The block SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have ports req0_i/req1_i  input  1  access request, port 0 = core load/store, port 1 = debug/DMA.
REQ-006 The block SHALL have ports we0_i/we1_i  input  1  write (1) or read (0) qualifier, valid with req.
REQ-007 The block SHALL have ports addr0_i/addr1_i  input  ADDRW  word address.
REQ-008 The block SHALL have ports wdata0_i/wdata1_i  input  DATAW  write data.
REQ-009 The block SHALL have ports gnt0_o/gnt1_o  output  1  request accepted this cycle.
REQ-010 The block SHALL have ports rvalid0_o/rvalid1_o  output  1  read data valid, one cycle after grant.
REQ-011 The block SHALL have port rdata_o  output  DATAW  registered read data, shared by both ports.
REQ-012 The block SHALL have ports mem_we_o  output  1, mem_memread_o  output  1, mem_addr_o  output  ADDRW, mem_wdata_o  output  DATAW  drive the data memory.
REQ-013 The block SHALL have port mem_rdata_i  input  DATAW  combinational read data from memory.

Function
REQ-014 The block SHALL grant at most one port per cycle; gnt is combinational from req and the arbitration pointer.
REQ-015 A requester SHALL hold req, we, addr, wdata stable until its gnt is high; a transfer occurs on a cycle where req and gnt are both high.
REQ-016 The block SHALL mux the granted port's addr, wdata and we onto mem_* in the grant cycle; mem_memread_o = grant & ~we; with no grant, mem_we_o=0, mem_memread_o=0, mem_addr_o=0, mem_wdata_o=0.
REQ-017 A granted write SHALL commit at the grant-cycle edge; it SHALL produce no rvalid.
REQ-018 A granted read SHALL capture mem_rdata_i into rdata_o at the grant-cycle edge and SHALL assert rvalid of that port for exactly the next cycle; latency 1, throughput 1 access/cycle.
REQ-019 rdata_o SHALL hold its value when no read completes.
REQ-020 Round-robin: a 1-bit pointer last_q records the last granted port; on simultaneous requests the port != last_q wins; last_q updates only on a grant.
REQ-021 A single requester SHALL be granted in the same cycle regardless of last_q.
REQ-022 Back-to-back requests from both ports SHALL alternate grants 0,1,0,1...; no port waits more than one cycle.

Reset
REQ-023 On rst_ni low the block SHALL asynchronously force last_q=1 (port 0 wins the first conflict), rvalid0_o=0, rvalid1_o=0, rdata_o=0.
REQ-024 Reset assertion mid-read SHALL drop the pending rvalid; no response follows reset release.
REQ-025 gnt and mem_* outputs SHALL be 0 while reset is asserted.

Configuration
REQ-026 With macro DMEM_ARB_FIXED_PRIO_EN defined, port 0 SHALL always win conflicts and last_q SHALL NOT exist; without it, REQ-020 round-robin SHALL apply.

Structure
REQ-027 A shared package SHALL hold the port-index constants (PORT_CORE=0, PORT_DBG=1) and default ADDRW/DATAW.
REQ-028 One sub-module, dmem_rr_pick, SHALL compute the 2-way grant from req vector and last_q.

Verification
REQ-029 Scenario: reset, req0 write addr 0x005 data 0xDEADBEEF -> gnt0 same cycle, mem_we_o=1 for one cycle, no rvalid.
REQ-030 Scenario: req0 read addr 0x005 after that write -> gnt0, next cycle rvalid0=1, rdata_o=0xDEADBEEF.
REQ-031 Scenario: req0 and req1 reads both held high 4 cycles after reset -> grants 0,1,0,1; rvalid pulses follow each by one cycle.
REQ-032 Scenario: req1 alone read addr 0x3FF -> gnt1 same cycle, rvalid1 next cycle, rvalid0 stays 0.
REQ-033 Scenario: rst_ni pulled low the cycle after a read grant -> rvalid0=0 and rdata_o=0 immediately; no response after release.
REQ-034 Scenario: DMEM_ARB_FIXED_PRIO_EN defined, both request 4 cycles -> gnt0 every cycle, gnt1 never.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared constants and types for the data-memory arbiter
package dmem_arbiter_pkg;

    // Requester port indices
    localparam int unsigned PORT_CORE = 0;
    localparam int unsigned PORT_DBG  = 1;

    // Default geometry of the data memory
    localparam int unsigned DMEM_ADDRW = 10;
    localparam int unsigned DMEM_DATAW = 32;

    // One bit per requester, indexed by PORT_CORE / PORT_DBG
    typedef logic [1:0] port_vec_t;

endpackage

// File: rtl/dmem_rr_pick.sv
// rtl/dmem_rr_pick.sv - two-way grant pick from request vector and last-granted pointer
module dmem_rr_pick
    import dmem_arbiter_pkg::*;
(
    input  port_vec_t req_i,
    input  logic      last_i,
    output port_vec_t gnt_o
);

    // A lone requester always wins; on a conflict the port that was not granted last wins
    always_comb begin
        gnt_o = '0;
        if (req_i[PORT_CORE] && req_i[PORT_DBG]) begin
            if (last_i) begin
                gnt_o[PORT_CORE] = 1'b1;
            end else begin
                gnt_o[PORT_DBG] = 1'b1;
            end
        end else begin
            gnt_o = req_i;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter, round-robin or fixed priority (DMEM_ARB_FIXED_PRIO_EN)
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDRW = DMEM_ADDRW,
    parameter int DATAW = DMEM_DATAW
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req0_i,
    input  logic             req1_i,
    input  logic             we0_i,
    input  logic             we1_i,
    input  logic [ADDRW-1:0] addr0_i,
    input  logic [ADDRW-1:0] addr1_i,
    input  logic [DATAW-1:0] wdata0_i,
    input  logic [DATAW-1:0] wdata1_i,
    output logic             gnt0_o,
    output logic             gnt1_o,
    output logic             rvalid0_o,
    output logic             rvalid1_o,
    output logic [DATAW-1:0] rdata_o,
    output logic             mem_we_o,
    output logic             mem_memread_o,
    output logic [ADDRW-1:0] mem_addr_o,
    output logic [DATAW-1:0] mem_wdata_o,
    input  logic [DATAW-1:0] mem_rdata_i
);

    port_vec_t        req;
    port_vec_t        pick;
    port_vec_t        gnt;
    logic             last_sel;
    logic             rd0;
    logic             rd1;
    logic             rvalid0_q, rvalid0_d;
    logic             rvalid1_q, rvalid1_d;
    logic [DATAW-1:0] rdata_q, rdata_d;

    assign req[PORT_CORE] = req0_i;
    assign req[PORT_DBG]  = req1_i;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // Pretending port 1 was always granted last makes port 0 win every conflict
    assign last_sel = 1'b1;
`else
    logic last_q, last_d;

    assign last_sel = last_q;

    // Pointer follows the most recent grant and holds otherwise
    always_comb begin
        last_d = last_q;
        if (gnt[PORT_DBG]) begin
            last_d = 1'b1;
        end else if (gnt[PORT_CORE]) begin
            last_d = 1'b0;
        end
    end

    // Pointer register; reset value 1 lets port 0 win the first conflict
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    dmem_rr_pick u_pick (
        .req_i  (req),
        .last_i (last_sel),
        .gnt_o  (pick)
    );

    // Grants are suppressed while reset is held so the memory sees no access
    assign gnt    = pick & {2{rst_ni}};
    assign gnt0_o = gnt[PORT_CORE];
    assign gnt1_o = gnt[PORT_DBG];
    assign rd0    = gnt[PORT_CORE] & ~we0_i;
    assign rd1    = gnt[PORT_DBG] & ~we1_i;

    // Steer the granted port onto the memory bus; idle bus is all zeros
    always_comb begin
        mem_we_o      = 1'b0;
        mem_memread_o = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        if (gnt[PORT_CORE]) begin
            mem_we_o      = we0_i;
            mem_memread_o = ~we0_i;
            mem_addr_o    = addr0_i;
            mem_wdata_o   = wdata0_i;
        end else if (gnt[PORT_DBG]) begin
            mem_we_o      = we1_i;
            mem_memread_o = ~we1_i;
            mem_addr_o    = addr1_i;
            mem_wdata_o   = wdata1_i;
        end
    end

    // Read response: capture memory data on a granted read, flag the owning port next cycle
    always_comb begin
        rvalid0_d = rd0;
        rvalid1_d = rd1;
        rdata_d   = rdata_q;
        if (rd0 || rd1) begin
            rdata_d = mem_rdata_i;
        end
    end

    // Response registers, cleared asynchronously so a pending read is dropped by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata_q   <= rdata_d;
        end
    end

    assign rvalid0_o = rvalid0_q;
    assign rvalid1_o = rvalid1_q;
    assign rdata_o   = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk;
    logic        rst_ni;
    logic        req0, req1, we0, we1;
    logic [9:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata;
    logic        mem_we, mem_rd;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    bit [31:0] env_mem [1024];
    bit [31:0] ref_mem [1024];

    int tests = 0;
    int fails = 0;

    dmem_arbiter #(.ADDRW(10), .DATAW(32)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .req0_i        (req0),
        .req1_i        (req1),
        .we0_i         (we0),
        .we1_i         (we1),
        .addr0_i       (addr0),
        .addr1_i       (addr1),
        .wdata0_i      (wdata0),
        .wdata1_i      (wdata1),
        .gnt0_o        (gnt0),
        .gnt1_o        (gnt1),
        .rvalid0_o     (rvalid0),
        .rvalid1_o     (rvalid1),
        .rdata_o       (rdata),
        .mem_we_o      (mem_we),
        .mem_memread_o (mem_rd),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory environment: combinational read, write at the clock edge
    assign mem_rdata = env_mem[mem_addr];
    always @(posedge clk) if (mem_we) env_mem[mem_addr] <= mem_wdata;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic r0, w0; logic [9:0] a0; logic [31:0] d0;
        logic r1, w1; logic [9:0] a1; logic [31:0] d1;
        logic g0, g1, mwe, mrd; logic [9:0] maddr; logic [31:0] mwd;
        logic rv0, rv1; logic [31:0] rd;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [9:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [9:0] a1, input logic [31:0] d1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_ni = 1'b0;
        next_cycle();
        rst_ni = 1'b1;
    endtask

    function automatic vec_t mk(input logic r0, input logic w0, input logic [9:0] a0, input logic [31:0] d0,
                                input logic r1, input logic w1, input logic [9:0] a1, input logic [31:0] d1,
                                input logic g0, input logic g1, input logic mwe, input logic mrd,
                                input logic [9:0] maddr, input logic [31:0] mwd,
                                input logic rv0, input logic rv1, input logic [31:0] rd);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.mwe = mwe; v.mrd = mrd; v.maddr = maddr; v.mwd = mwd;
        v.rv0 = rv0; v.rv1 = rv1; v.rd = rd;
        return v;
    endfunction

    vec_t vecs [10];

    initial begin
        int          last_w;
        int          w;
        int          exp_w;
        bit          p_req [2];
        bit          p_we [2];
        logic [9:0]  p_addr [2];
        logic [31:0] p_wd [2];
        bit          exp_rv [2];
        logic [31:0] exp_rd;
        logic [9:0]  exp_maddr;

        // Rows are consecutive cycles; rvalid/rdata columns show the previous cycle's read
        vecs[0] = mk(1,1,10'h005,32'hDEADBEEF, 0,0,0,0,          1,0,1,0,10'h005,32'hDEADBEEF, 0,0,32'h0);
        vecs[1] = mk(0,0,0,0,                  0,0,0,0,          0,0,0,0,10'h000,32'h0,        0,0,32'h0);
        vecs[2] = mk(1,0,10'h005,0,            0,0,0,0,          1,0,0,1,10'h005,32'h0,        0,0,32'h0);
        vecs[3] = mk(0,0,0,0,                  0,0,0,0,          0,0,0,0,10'h000,32'h0,        1,0,32'hDEADBEEF);
        vecs[4] = mk(0,0,0,0,                  1,0,10'h005,0,    0,1,0,1,10'h005,32'h0,        0,0,32'hDEADBEEF);
        vecs[5] = mk(1,0,10'h005,0,            0,0,0,0,          1,0,0,1,10'h005,32'h0,        0,1,32'hDEADBEEF);
        vecs[6] = mk(0,0,0,0,                  1,1,10'h3FF,32'h12345678, 0,1,1,0,10'h3FF,32'h12345678, 1,0,32'hDEADBEEF);
        vecs[7] = mk(0,0,0,0,                  1,0,10'h3FF,0,    0,1,0,1,10'h3FF,32'h0,        0,0,32'hDEADBEEF);
        vecs[8] = mk(0,0,0,0,                  0,0,0,0,          0,0,0,0,10'h000,32'h0,        0,1,32'h12345678);
        vecs[9] = mk(0,0,0,0,                  0,0,0,0,          0,0,0,0,10'h000,32'h0,        0,0,32'h12345678);

        // Reset with both ports requesting: everything quiet
        rst_ni = 1'b0;
        drive(1, 1, 10'h005, 32'hDEADBEEF, 1, 0, 10'h3FF, 0);
        @(negedge clk);
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_rvalid1", rvalid1, 0);
        chk("rst_rdata", rdata, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_ni = 1'b1;

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            drive(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
                  vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
            @(negedge clk);
            chk($sformatf("vec%0d_gnt0", i), gnt0, vecs[i].g0);
            chk($sformatf("vec%0d_gnt1", i), gnt1, vecs[i].g1);
            chk($sformatf("vec%0d_mem_we", i), mem_we, vecs[i].mwe);
            chk($sformatf("vec%0d_mem_rd", i), mem_rd, vecs[i].mrd);
            chk($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].maddr);
            chk($sformatf("vec%0d_mem_wdata", i), mem_wdata, vecs[i].mwd);
            chk($sformatf("vec%0d_rvalid0", i), rvalid0, vecs[i].rv0);
            chk($sformatf("vec%0d_rvalid1", i), rvalid1, vecs[i].rv1);
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].rd);
        end
        ref_mem[10'h005] = 32'hDEADBEEF;
        ref_mem[10'h3FF] = 32'h12345678;

        // Both ports read continuously right after reset: alternate (or port 0 always when fixed)
        do_reset();
        exp_rv[0] = 0; exp_rv[1] = 0; exp_rd = 32'h0;
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            drive(1, 0, 10'h005, 0, 1, 0, 10'h3FF, 0);
            @(negedge clk);
            exp_w = FIXED ? 0 : (c % 2);
            chk($sformatf("alt%0d_gnt0", c), gnt0, exp_w == 0);
            chk($sformatf("alt%0d_gnt1", c), gnt1, exp_w == 1);
            chk($sformatf("alt%0d_rvalid0", c), rvalid0, exp_rv[0]);
            chk($sformatf("alt%0d_rvalid1", c), rvalid1, exp_rv[1]);
            chk($sformatf("alt%0d_rdata", c), rdata, exp_rd);
            exp_rv[0] = (exp_w == 0);
            exp_rv[1] = (exp_w == 1);
            exp_rd = (exp_w == 0) ? ref_mem[10'h005] : ref_mem[10'h3FF];
        end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("alt_tail_rvalid0", rvalid0, exp_rv[0]);
        chk("alt_tail_rvalid1", rvalid1, exp_rv[1]);
        chk("alt_tail_rdata", rdata, exp_rd);

        // Reset asserted the cycle after a read grant drops the response
        next_cycle();
        drive(1, 0, 10'h005, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("midrst_gnt0", gnt0, 1);
        next_cycle();
        drive(1, 0, 10'h005, 0, 0, 0, 0, 0);
        chk("midrst_rvalid0_before", rvalid0, 1);
        chk("midrst_rdata_before", rdata, ref_mem[10'h005]);
        #1 rst_ni = 1'b0;
        #1;
        chk("midrst_rvalid0", rvalid0, 0);
        chk("midrst_rdata", rdata, 0);
        chk("midrst_gnt0_held", gnt0, 0);
        chk("midrst_mem_rd", mem_rd, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_ni = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            @(negedge clk);
            chk($sformatf("postrst%0d_rvalid0", c), rvalid0, 0);
            chk($sformatf("postrst%0d_rvalid1", c), rvalid1, 0);
        end

        // Randomized traffic against a transaction-level model
        do_reset();
        last_w = 1;
        exp_rd = 32'h0;
        for (int p = 0; p < 2; p++) begin
            p_req[p] = 0; p_we[p] = 0; p_addr[p] = 0; p_wd[p] = 0; exp_rv[p] = 0;
        end
        for (int c = 0; c < 500; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!p_req[p] && $urandom_range(0, 3) != 0) begin
                    p_req[p]  = 1;
                    p_we[p]   = $urandom_range(0, 1) == 1;
                    p_addr[p] = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                                            : 10'($urandom_range(0, 15));
                    p_wd[p]   = $urandom;
                end
            end
            next_cycle();
            drive(p_req[0], p_we[0], p_addr[0], p_wd[0], p_req[1], p_we[1], p_addr[1], p_wd[1]);
            if (p_req[0] && p_req[1]) w = FIXED ? 0 : (last_w == 0 ? 1 : 0);
            else if (p_req[0]) w = 0;
            else if (p_req[1]) w = 1;
            else w = -1;
            exp_maddr = (w >= 0) ? p_addr[w] : 10'h0;
            @(negedge clk);
            chk("rnd_gnt0", gnt0, w == 0);
            chk("rnd_gnt1", gnt1, w == 1);
            chk("rnd_mem_we", mem_we, (w >= 0) && p_we[w]);
            chk("rnd_mem_rd", mem_rd, (w >= 0) && !p_we[w]);
            chk("rnd_mem_addr", mem_addr, exp_maddr);
            chk("rnd_rvalid0", rvalid0, exp_rv[0]);
            chk("rnd_rvalid1", rvalid1, exp_rv[1]);
            chk("rnd_rdata", rdata, exp_rd);
            exp_rv[0] = 0;
            exp_rv[1] = 0;
            if (w >= 0) begin
                if (p_we[w]) begin
                    ref_mem[p_addr[w]] = p_wd[w];
                end else begin
                    exp_rv[w] = 1;
                    exp_rd = ref_mem[p_addr[w]];
                end
                last_w = w;
                p_req[w] = 0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
